enemy_wave_scheduler: RTL and testbench
=======================================

ENEMY_WAVE_SCHEDULER -- requirements
Module: enemy_wave_scheduler

Interface
REQ-001 The module SHALL have parameter NE, default 8, number of enemy ships per wave.
REQ-002 The module SHALL have parameter NM, default 16, number of schedule steps per movement loop.
REQ-003 The module SHALL have parameter STEP_FRAMES, default 4, frames per schedule step.
REQ-004 The module SHALL have parameter CLEAR_FRAMES, default 60, pause frames between waves.
REQ-005 The module SHALL have parameter NWAVE, default 4, waves per game (max 8).
REQ-006 frame_clk  input  1  the single clock, one tick per video frame.
REQ-007 Reset  input  1  synchronous, active-low reset.
REQ-008 Start  input  1  level; starts the game when sampled high in IDLE or DONE.
REQ-009 EShipColl  input  NE  per-enemy hit pulse from collision logic.
REQ-010 FireReq  input  NE  per-enemy fire request for this frame.
REQ-011 ProjSlotFree  input  1  the shared enemy projectile slot is free.
REQ-012 ESchedCtr  output  10  current schedule step index, drives enemy position lookup.
REQ-013 WaveNum  output  3  current wave index, 0..NWAVE-1.
REQ-014 EShipAlive  output  NE  per-enemy alive flags.
REQ-015 FireGrant  output  NE  one-hot or zero, registered, a one-cycle fire grant.
REQ-016 WaveActive  output  1  high only in RUN.
REQ-017 GameDone  output  1  high only in DONE.

Function
REQ-018 The FSM SHALL have states IDLE, SPAWN, RUN, CLEAR and DONE.
REQ-019 IDLE->SPAWN on Start=1; DONE->SPAWN on Start=1 with WaveNum reset to 0; Start SHALL be ignored in every other state.
REQ-020 SPAWN SHALL last exactly 1 cycle: EShipAlive<=all ones, ESchedCtr<=0, step counter<=0, then RUN.
REQ-021 In RUN the step counter SHALL count 0..STEP_FRAMES-1; on terminal count ESchedCtr SHALL increment, wrapping from NM-1 to 0.
REQ-022 On each cycle, EShipAlive SHALL clear every bit i where EShipColl[i]=1; hits on bits already 0 SHALL be ignored.
REQ-023 RUN->CLEAR in the cycle after EShipAlive becomes all zero; ESchedCtr SHALL then hold.
REQ-024 CLEAR SHALL count CLEAR_FRAMES cycles, then go to SPAWN with WaveNum+1 if WaveNum<NWAVE-1, else go to DONE with WaveNum held.
REQ-025 Fire eligibility: eligible[i] = FireReq[i] & EShipAlive[i] & ~EShipColl[i]; a collision in the same cycle SHALL beat a fire request.
REQ-026 When state=RUN and ProjSlotFree=1 and any bit is eligible, FireGrant SHALL be the next cycle's one-hot of the first eligible index at or after the round-robin pointer, searching cyclically.
REQ-027 After a grant to index g, the pointer SHALL become (g+1) mod NE; with no grant the pointer SHALL hold.
REQ-028 FireGrant SHALL be zero in every cycle following a cycle that is not in RUN, has ProjSlotFree=0, or has no eligible bit.
REQ-029 After a grant, FireGrant SHALL be forced to zero for the next cycle, so that the consumer can drop ProjSlotFree.

Reset
REQ-030 Reset=0 at a clock edge SHALL force state=IDLE, ESchedCtr=0, WaveNum=0, EShipAlive=0, FireGrant=0, pointer=0, and both counters=0; WaveActive=0 and GameDone=0 follow from the state.
REQ-031 Reset SHALL take priority over all inputs, including in the middle of RUN or CLEAR, and the block SHALL stay in IDLE until Start after Reset returns high.

Verification
REQ-032 Reset, then Start=1 for 1 cycle -> SPAWN for 1 cycle, then RUN with EShipAlive=8'hFF; ESchedCtr=1 after 4 RUN cycles, and it wraps 15->0 after 64 RUN cycles.
REQ-033 In RUN with ProjSlotFree=1 and FireReq=8'b1000_0101 held -> grants in order 0,2,7,0 on alternating cycles, with zero between them.
REQ-034 FireReq[3]=1 and EShipColl[3]=1 in the same cycle -> no grant to 3, and EShipAlive[3]=0 on the next cycle.
REQ-035 Hit all 8 ships -> CLEAR the cycle after the last hit, 60 cycles of CLEAR, then SPAWN with WaveNum=1; after wave 3 is cleared -> DONE with GameDone=1, and Start returns to SPAWN with WaveNum=0.
REQ-036 Reset=0 for 1 cycle during RUN with ESchedCtr=7 -> all outputs are at reset values the next cycle, and Start is then required to resume.

Source files
------------

// File: rtl/enemy_wave_scheduler.sv
// enemy_wave_scheduler: sequences enemy waves for one game.
//   IDLE -> SPAWN -> RUN -> CLEAR -> (SPAWN | DONE); DONE -> SPAWN on Start.
//   Also arbitrates per-enemy fire requests onto one shared projectile slot.
// Ports:
//   frame_clk     in   one tick per video frame
//   Reset         in   synchronous, active-low
//   Start         in   starts a game from IDLE or DONE
//   EShipColl     in   [NE] per-enemy hit pulses
//   FireReq       in   [NE] per-enemy fire requests
//   ProjSlotFree  in   shared enemy projectile slot is free
//   ESchedCtr     out  [10] movement schedule step index
//   WaveNum       out  [3] current wave index
//   EShipAlive    out  [NE] per-enemy alive flags
//   FireGrant     out  [NE] one-cycle one-hot fire grant (or zero)
//   WaveActive    out  high in RUN
//   GameDone      out  high in DONE
module enemy_wave_scheduler #(
    parameter int unsigned NE           = 8,
    parameter int unsigned NM           = 16,
    parameter int unsigned STEP_FRAMES  = 4,
    parameter int unsigned CLEAR_FRAMES = 60,
    parameter int unsigned NWAVE        = 4
) (
    input  logic          frame_clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [NE-1:0] EShipColl,
    input  logic [NE-1:0] FireReq,
    input  logic          ProjSlotFree,
    output logic [9:0]    ESchedCtr,
    output logic [2:0]    WaveNum,
    output logic [NE-1:0] EShipAlive,
    output logic [NE-1:0] FireGrant,
    output logic          WaveActive,
    output logic          GameDone
);

    localparam int unsigned PW = (NE > 1) ? $clog2(NE) : 1;
    localparam int unsigned SW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam int unsigned CW = (CLEAR_FRAMES > 1) ? $clog2(CLEAR_FRAMES) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPAWN = 3'd1,
        RUN   = 3'd2,
        CLEAR = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state, nextState;
    logic [SW-1:0] stepCtr, stepNext;
    logic [CW-1:0] clearCtr, clearNext;
    logic [PW-1:0] ptr, ptrNext;
    logic [9:0]    schedNext;
    logic [2:0]    waveNext;
    logic [NE-1:0] aliveNext, grantNext, eligible;
    logic [PW-1:0] pick;
    logic          found, stepTerm, clearTerm;
    int unsigned   scanIdx;

    // State and datapath registers
    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            state      <= IDLE;
            stepCtr    <= '0;
            clearCtr   <= '0;
            ptr        <= '0;
            ESchedCtr  <= '0;
            WaveNum    <= '0;
            EShipAlive <= '0;
            FireGrant  <= '0;
            WaveActive <= 1'b0;
            GameDone   <= 1'b0;
        end else begin
            state      <= nextState;
            stepCtr    <= stepNext;
            clearCtr   <= clearNext;
            ptr        <= ptrNext;
            ESchedCtr  <= schedNext;
            WaveNum    <= waveNext;
            EShipAlive <= aliveNext;
            FireGrant  <= grantNext;
            WaveActive <= (nextState == RUN);
            GameDone   <= (nextState == DONE);
        end
    end

    // Round-robin search for the first eligible shooter at or after ptr
    always_comb begin
        eligible = FireReq & EShipAlive & ~EShipColl;
        found    = 1'b0;
        pick     = '0;
        scanIdx  = 0;
        for (int unsigned i = 0; i < NE; i++) begin
            scanIdx = (32'(ptr) + i) % NE;
            if (!found && eligible[PW'(scanIdx)]) begin
                found = 1'b1;
                pick  = PW'(scanIdx);
            end
        end
    end

    // Next-state and datapath updates
    always_comb begin
        nextState = state;
        stepNext  = stepCtr;
        clearNext = '0;
        ptrNext   = ptr;
        schedNext = ESchedCtr;
        waveNext  = WaveNum;
        aliveNext = EShipAlive & ~EShipColl;
        grantNext = '0;
        stepTerm  = (stepCtr == SW'(STEP_FRAMES - 1));
        clearTerm = (clearCtr == CW'(CLEAR_FRAMES - 1));

        unique case (state)
            IDLE, DONE: begin
                if (Start) begin
                    nextState = SPAWN;
                    waveNext  = '0;
                end
            end
            SPAWN: begin
                nextState = RUN;
                aliveNext = '1;
                schedNext = '0;
                stepNext  = '0;
            end
            RUN: begin
                stepNext = stepTerm ? '0 : stepCtr + 1'b1;
                if (stepTerm) begin
                    schedNext = (ESchedCtr == 10'(NM - 1)) ? 10'd0 : ESchedCtr + 10'd1;
                end
                // Alive flags are registered, so the wave ends one frame after the last kill lands
                if (EShipAlive == '0) begin
                    nextState = CLEAR;
                end
                // A grant is always followed by an idle frame so the consumer can take the slot
                if (ProjSlotFree && found && (FireGrant == '0)) begin
                    grantNext[pick] = 1'b1;
                    ptrNext = (pick == PW'(NE - 1)) ? '0 : pick + 1'b1;
                end
            end
            CLEAR: begin
                clearNext = clearCtr + 1'b1;
                if (clearTerm) begin
                    clearNext = '0;
                    if (WaveNum < 3'(NWAVE - 1)) begin
                        nextState = SPAWN;
                        waveNext  = WaveNum + 3'd1;
                    end else begin
                        nextState = DONE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// tb_enemy_wave_scheduler: directed stimulus against a frame-level behavioural model.
module tb_enemy_wave_scheduler;

    localparam int NE = 8;
    localparam int NM = 16;
    localparam int STEP_FRAMES = 4;
    localparam int CLEAR_FRAMES = 60;
    localparam int NWAVE = 4;

    localparam int P_IDLE = 0, P_SPAWN = 1, P_RUN = 2, P_CLEAR = 3, P_DONE = 4;

    logic          clk;
    logic          rstN;
    logic          start;
    logic [NE-1:0] coll;
    logic [NE-1:0] fireReq;
    logic          slotFree;
    logic [9:0]    schedCtr;
    logic [2:0]    waveNum;
    logic [NE-1:0] alive;
    logic [NE-1:0] grant;
    logic          waveActive;
    logic          gameDone;

    int nChecks = 0;
    int nPass = 0;
    bit checkEn = 0;

    // Model state: phase, frames spent in RUN this wave, frames in CLEAR, etc.
    int            mPhase;
    int            mRun;
    int            mClear;
    int            mWave;
    int            mPtr;
    logic [NE-1:0] mAlive;
    logic [NE-1:0] mGrant;

    enemy_wave_scheduler dut (
        .frame_clk   (clk),
        .Reset       (rstN),
        .Start       (start),
        .EShipColl   (coll),
        .FireReq     (fireReq),
        .ProjSlotFree(slotFree),
        .ESchedCtr   (schedCtr),
        .WaveNum     (waveNum),
        .EShipAlive  (alive),
        .FireGrant   (grant),
        .WaveActive  (waveActive),
        .GameDone    (gameDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int expSched();
        return (mRun / STEP_FRAMES) % NM;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model, one update per frame
    always @(posedge clk) begin : model_b
        logic [NE-1:0] elig, nGrant, nAlive;
        logic [2:0]    ix;
        int            nPhase, nPtr, nWave, nRun, nClear;
        bit            hit;
        if (!rstN) begin
            mPhase <= P_IDLE; mRun <= 0; mClear <= 0; mWave <= 0;
            mPtr <= 0; mAlive <= '0; mGrant <= '0;
        end else begin
            elig   = fireReq & mAlive & ~coll;
            nGrant = '0;
            nPtr   = mPtr;
            hit    = 0;
            if (mPhase == P_RUN && slotFree && mGrant == '0) begin
                for (int k = 0; k < NE; k++) begin
                    ix = 3'((mPtr + k) % NE);
                    if (!hit && elig[ix]) begin
                        hit = 1;
                        nGrant[ix] = 1'b1;
                        nPtr = (int'(ix) + 1) % NE;
                    end
                end
            end
            nAlive = (mPhase == P_SPAWN) ? '1 : (mAlive & ~coll);
            nPhase = mPhase; nRun = mRun; nClear = mClear; nWave = mWave;
            case (mPhase)
                P_IDLE, P_DONE: if (start) begin nPhase = P_SPAWN; nWave = 0; end
                P_SPAWN: begin nPhase = P_RUN; nRun = 0; end
                P_RUN: begin
                    nRun = mRun + 1;
                    if (mAlive == '0) begin nPhase = P_CLEAR; nClear = 0; end
                end
                P_CLEAR: begin
                    nClear = mClear + 1;
                    if (nClear == CLEAR_FRAMES) begin
                        if (mWave < NWAVE - 1) begin nPhase = P_SPAWN; nWave = mWave + 1; end
                        else nPhase = P_DONE;
                    end
                end
                default: nPhase = P_IDLE;
            endcase
            mPhase <= nPhase; mRun <= nRun; mClear <= nClear; mWave <= nWave;
            mPtr <= nPtr; mAlive <= nAlive; mGrant <= nGrant;
        end
    end

    // Every-frame comparison of all outputs against the model
    always @(negedge clk) begin
        if (checkEn) begin
            cmp("m_sched", 32'(schedCtr), 32'(expSched()));
            cmp("m_wave", 32'(waveNum), 32'(mWave));
            cmp("m_alive", 32'(alive), 32'(mAlive));
            cmp("m_grant", 32'(grant), 32'(mGrant));
            cmp("m_active", 32'(waveActive), 32'(mPhase == P_RUN));
            cmp("m_done", 32'(gameDone), 32'(mPhase == P_DONE));
        end
    end

    initial begin
        rstN = 1'b0; start = 1'b0; coll = '0; fireReq = '0; slotFree = 1'b0;
        tick(1);
        checkEn = 1;
        tick(1);
        cmp("rst_sched", 32'(schedCtr), 32'd0);
        cmp("rst_alive", 32'(alive), 32'd0);
        cmp("rst_grant", 32'(grant), 32'd0);
        cmp("rst_active", 32'(waveActive), 32'd0);
        rstN = 1'b1;
        tick(3);
        cmp("idle_active", 32'(waveActive), 32'd0);

        // Start, spawn, schedule stepping and wrap
        start = 1'b1;
        tick(1);
        cmp("spawn_active", 32'(waveActive), 32'd0);
        start = 1'b0;
        tick(1);
        cmp("run_alive", 32'(alive), 32'hFF);
        cmp("run_active", 32'(waveActive), 32'd1);
        tick(4);
        cmp("sched_1", 32'(schedCtr), 32'd1);
        tick(59);
        cmp("sched_15", 32'(schedCtr), 32'd15);
        tick(1);
        cmp("sched_wrap", 32'(schedCtr), 32'd0);

        // Round-robin grants with idle frames between them
        fireReq = 8'b1000_0101; slotFree = 1'b1;
        tick(1); cmp("rr_g0", 32'(grant), 32'h01);
        tick(1); cmp("rr_z0", 32'(grant), 32'h00);
        tick(1); cmp("rr_g2", 32'(grant), 32'h04);
        tick(1); cmp("rr_z1", 32'(grant), 32'h00);
        tick(1); cmp("rr_g7", 32'(grant), 32'h80);
        tick(1); cmp("rr_z2", 32'(grant), 32'h00);
        tick(1); cmp("rr_g0b", 32'(grant), 32'h01);
        fireReq = '0;
        tick(2);

        // Collision beats a same-frame fire request
        fireReq = 8'h08; coll = 8'h08;
        tick(1);
        cmp("coll_nogrant", 32'(grant), 32'h00);
        cmp("coll_alive", 32'(alive), 32'hF7);
        coll = '0;
        tick(2);
        cmp("dead_nogrant", 32'(grant), 32'h00);
        fireReq = '0;

        // Busy slot blocks grants
        fireReq = 8'h01; slotFree = 1'b0;
        tick(2);
        cmp("busy_nogrant", 32'(grant), 32'h00);
        slotFree = 1'b1;
        tick(1);
        cmp("free_grant", 32'(grant), 32'h01);
        fireReq = '0; slotFree = 1'b0;

        // Reset in the middle of RUN at schedule step 7
        for (int k = 0; k < 200 && expSched() != 7; k++) tick(1);
        cmp("pre_rst_sched7", 32'(schedCtr), 32'd7);
        rstN = 1'b0;
        tick(1);
        cmp("mid_rst_sched", 32'(schedCtr), 32'd0);
        cmp("mid_rst_alive", 32'(alive), 32'd0);
        cmp("mid_rst_active", 32'(waveActive), 32'd0);
        cmp("mid_rst_wave", 32'(waveNum), 32'd0);
        rstN = 1'b1;
        tick(4);
        cmp("stay_idle", 32'(waveActive), 32'd0);

        // Full game: NWAVE waves, each cleared with staggered and repeated hits
        start = 1'b1;
        tick(1);
        start = 1'b0;
        cmp("g_wave0", 32'(waveNum), 32'd0);
        for (int w = 0; w < NWAVE; w++) begin
            tick(1);
            cmp("g_run", 32'(waveActive), 32'd1);
            for (int s = 0; s < NE; s++) begin
                int b;
                logic [NE-1:0] m;
                b = (w % 2 == 1) ? (NE - 1 - s) : s;
                m = '0;
                m[3'(b)] = 1'b1;
                if (s > 0) m[3'((w % 2 == 1) ? b + 1 : b - 1)] = 1'b1;
                coll = m;
                fireReq = NE'($urandom);
                slotFree = 1'b1;
                start = 1'b1;
                tick(1);
            end
            coll = '0; fireReq = '0; start = 1'b0; slotFree = 1'b0;
            cmp("g_all_dead", 32'(alive), 32'd0);
            cmp("g_still_run", 32'(waveActive), 32'd1);
            tick(1);
            cmp("g_clear", 32'(waveActive), 32'd0);
            tick(CLEAR_FRAMES - 1);
            cmp("g_clear_end", 32'(gameDone), 32'd0);
            tick(1);
            if (w < NWAVE - 1) begin
                cmp("g_next_wave", 32'(waveNum), 32'(w + 1));
            end else begin
                cmp("g_done", 32'(gameDone), 32'd1);
                cmp("g_done_wave", 32'(waveNum), 32'd3);
            end
        end
        tick(3);
        cmp("done_hold", 32'(gameDone), 32'd1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        cmp("restart_wave", 32'(waveNum), 32'd0);
        cmp("restart_done", 32'(gameDone), 32'd0);
        tick(1);
        cmp("restart_alive", 32'(alive), 32'hFF);
        tick(2);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
